// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data RAM bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY_I = 3'd1,
    ST_BUSY_D = 3'd2,
    ST_DONE_I = 3'd3,
    ST_DONE_D = 3'd4
  } arb_state_t;

  localparam int          WAIT_CYCLES_DEFAULT = 2;
  localparam logic [3:0]  SEL_FULL            = 4'b1111;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one fixed-latency single-port RAM bus between instruction
// fetch and the MEM-stage load/store port. Data side wins ties.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | bus free; grant data request first, else fetch request
// BUSY_I  | fetch on the bus; counts WAIT_CYCLES, samples on the last one
// BUSY_D  | load/store on the bus; same timing as BUSY_I
// DONE_I  | fetch result presented, fetch stall released for this cycle
// DONE_D  | load result presented, data stall released for this cycle
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_stallreq_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_stallreq_o,
  input  logic        flush_i,
  output logic        bus_ce_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              discard_q, discard_d;
  logic              bus_ce_d, bus_we_d;
  logic [3:0]        bus_sel_d;
  logic [31:0]       bus_addr_d, bus_data_d;
  logic [31:0]       if_data_d, mem_data_d;
  logic              finish;

  // Stall requests follow the requester's ce, released only in its DONE cycle.
  assign if_stallreq_o  = reset_n & if_ce_i  & (state_q != ST_DONE_I);
  assign mem_stallreq_o = reset_n & mem_ce_i & (state_q != ST_DONE_D);

  // Register all FSM state, the wait counter and the bus/result registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      discard_q  <= 1'b0;
      bus_ce_o   <= 1'b0;
      bus_we_o   <= 1'b0;
      bus_sel_o  <= '0;
      bus_addr_o <= '0;
      bus_data_o <= '0;
      if_data_o  <= '0;
      mem_data_o <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      discard_q  <= discard_d;
      bus_ce_o   <= bus_ce_d;
      bus_we_o   <= bus_we_d;
      bus_sel_o  <= bus_sel_d;
      bus_addr_o <= bus_addr_d;
      bus_data_o <= bus_data_d;
      if_data_o  <= if_data_d;
      mem_data_o <= mem_data_d;
    end
  end

  // Next-state, grant latching, wait counting and result capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    discard_d  = discard_q;
    bus_ce_d   = bus_ce_o;
    bus_we_d   = bus_we_o;
    bus_sel_d  = bus_sel_o;
    bus_addr_d = bus_addr_o;
    bus_data_d = bus_data_o;
    if_data_d  = if_data_o;
    mem_data_d = mem_data_o;
    finish     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        discard_d = 1'b0;
        if (mem_ce_i) begin
          bus_ce_d   = 1'b1;
          bus_we_d   = mem_we_i;
          bus_sel_d  = mem_sel_i;
          bus_addr_d = mem_addr_i;
          bus_data_d = mem_data_i;
          state_d    = ST_BUSY_D;
        end else if (if_ce_i) begin
          bus_ce_d   = 1'b1;
          bus_we_d   = 1'b0;
          bus_sel_d  = SEL_FULL;
          bus_addr_d = if_addr_i;
          bus_data_d = '0;
          state_d    = ST_BUSY_I;
        end
      end
      ST_BUSY_I: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (flush_i) discard_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          finish    = 1'b1;
          discard_d = 1'b0;
          // A flush seen at any point of the fetch drops its result; the
          // bus cycle itself is never cut short.
          if (discard_q || flush_i) begin
            state_d = ST_IDLE;
          end else begin
            if_data_d = bus_data_i;
            state_d   = ST_DONE_I;
          end
        end
      end
      ST_BUSY_D: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          finish     = 1'b1;
          mem_data_d = bus_we_o ? 32'd0 : bus_data_i;
          state_d    = ST_DONE_D;
        end
      end
      ST_DONE_I, ST_DONE_D: begin
        state_d = ST_IDLE;
      end
      default: begin
        finish  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    if (finish) begin
      cnt_d      = '0;
      bus_ce_d   = 1'b0;
      bus_we_d   = 1'b0;
      bus_sel_d  = '0;
      bus_addr_d = '0;
      bus_data_d = '0;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus queues expected bus beats and
// results, a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_bus_arbiter;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_ce_i, mem_ce_i, mem_we_i, flush_i;
  logic [31:0] if_addr_i, mem_addr_i, mem_data_i, bus_data_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] if_data_o, mem_data_o, bus_addr_o, bus_data_o;
  logic        if_stallreq_o, mem_stallreq_o, bus_ce_o, bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] ram_rd;

  // Second instance built with WAIT_CYCLES=1, fetch side only.
  logic        if_ce1;
  logic [31:0] if_addr1, if_data1, bus_addr1, bus_data1, bus_rd1;
  logic        if_stall1, mem_stall1, bus_ce1, bus_we1;
  logic [3:0]  bus_sel1;
  logic [31:0] mem_data1;
  logic        zero1 = 1'b0;
  logic [3:0]  zero4 = 4'd0;
  logic [31:0] zero32 = 32'd0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  beat_t       exp_bus[$];
  logic [31:0] exp_if[$];
  logic [31:0] exp_mem[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus_data_i = ram_rd;
  assign bus_rd1    = bus_addr1 ^ 32'hFFFF_0000;

  mem_bus_arbiter #(.WAIT_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
    .if_stallreq_o(if_stallreq_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .mem_stallreq_o(mem_stallreq_o), .flush_i(flush_i),
    .bus_ce_o(bus_ce_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_data_i(bus_data_i)
  );

  mem_bus_arbiter #(.WAIT_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .if_ce_i(if_ce1), .if_addr_i(if_addr1), .if_data_o(if_data1),
    .if_stallreq_o(if_stall1),
    .mem_ce_i(zero1), .mem_we_i(zero1), .mem_sel_i(zero4),
    .mem_addr_i(zero32), .mem_data_i(zero32), .mem_data_o(mem_data1),
    .mem_stallreq_o(mem_stall1), .flush_i(zero1),
    .bus_ce_o(bus_ce1), .bus_we_o(bus_we1), .bus_sel_o(bus_sel1),
    .bus_addr_o(bus_addr1), .bus_data_o(bus_data1), .bus_data_i(bus_rd1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input int n, input beat_t b);
    for (int i = 0; i < n; i++) exp_bus.push_back(b);
  endtask

  // Counts stalled negedges until the selected stall falls (bounded).
  task automatic wait_low(input bit mem_side, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!(mem_side ? mem_stallreq_o : if_stallreq_o)) return;
      n++;
    end
    chk("stall_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: bus beats, idle-bus zeros, and results in DONE cycles.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (bus_ce_o) begin
        if (exp_bus.size() == 0) begin
          chk("bus_unexpected_beat", bus_addr_o, 32'hFFFF_FFFF);
        end else begin
          beat_t b;
          b = exp_bus.pop_front();
          chk("bus_we",   {31'd0, bus_we_o}, {31'd0, b.we});
          chk("bus_sel",  {28'd0, bus_sel_o}, {28'd0, b.sel});
          chk("bus_addr", bus_addr_o, b.addr);
          chk("bus_data", bus_data_o, b.data);
        end
      end else begin
        chk("bus_idle_zero", {bus_we_o, bus_sel_o, 27'd0} | bus_addr_o | bus_data_o, 32'd0);
      end
      if (if_ce_i && !if_stallreq_o) begin
        if (exp_if.size() == 0) chk("if_unexpected_done", if_data_o, 32'hFFFF_FFFF);
        else chk("if_data", if_data_o, exp_if.pop_front());
      end
      if (mem_ce_i && !mem_stallreq_o) begin
        if (exp_mem.size() == 0) chk("mem_unexpected_done", mem_data_o, 32'hFFFF_FFFF);
        else chk("mem_data", mem_data_o, exp_mem.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_if, n_mem, hi, last_done;
    reset_n = 1'b0; if_ce_i = 0; mem_ce_i = 0; mem_we_i = 0; flush_i = 0;
    if_addr_i = 0; mem_addr_i = 0; mem_data_i = 0; mem_sel_i = 0; ram_rd = 0;
    if_ce1 = 0; if_addr1 = 0;

    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_bus_ce", {31'd0, bus_ce_o}, 32'd0);
    chk("rst_if_data", if_data_o, 32'd0);
    chk("rst_mem_data", mem_data_o, 32'd0);
    tick(); reset_n = 1'b1;
    tick();

    // Uncontended fetch
    ram_rd = 32'h3C01_0001;
    push_beats(2, '{we: 1'b0, sel: 4'hF, addr: 32'h100, data: 32'h0});
    exp_if.push_back(32'h3C01_0001);
    if_ce_i = 1; if_addr_i = 32'h100;
    wait_low(1'b0, n_if);
    chk("fetch_stall_cycles", n_if, 32'd3);
    tick(); if_ce_i = 0;
    @(negedge clk);
    chk("fetch_data_held", if_data_o, 32'h3C01_0001);

    // Byte-lane store
    tick();
    push_beats(2, '{we: 1'b1, sel: 4'b0011, addr: 32'h202, data: 32'h0000_BEEF});
    exp_mem.push_back(32'h0);
    mem_ce_i = 1; mem_we_i = 1; mem_sel_i = 4'b0011; mem_addr_i = 32'h202; mem_data_i = 32'hBEEF;
    wait_low(1'b1, n_mem);
    chk("store_stall_cycles", n_mem, 32'd3);
    tick(); mem_ce_i = 0; mem_we_i = 0; mem_data_i = 0; mem_sel_i = 4'hF;

    // Simultaneous load + fetch: data first
    tick();
    ram_rd = 32'h1234_5678;
    push_beats(2, '{we: 1'b0, sel: 4'hF, addr: 32'h80, data: 32'h0});
    push_beats(2, '{we: 1'b0, sel: 4'hF, addr: 32'h104, data: 32'h0});
    exp_mem.push_back(32'h1234_5678);
    exp_if.push_back(32'h1234_5678);
    mem_ce_i = 1; mem_addr_i = 32'h80; if_ce_i = 1; if_addr_i = 32'h104;
    fork
      begin wait_low(1'b1, n_mem); tick(); mem_ce_i = 0; end
      begin wait_low(1'b0, n_if); tick(); if_ce_i = 0; end
    join
    chk("contend_mem_stall", n_mem, 32'd3);
    chk("contend_if_stall", n_if, 32'd7);

    // Fetch flushed in its 2nd bus cycle, request held so it re-issues
    tick();
    ram_rd = 32'hDEAD_DEAD;
    push_beats(2, '{we: 1'b0, sel: 4'hF, addr: 32'h200, data: 32'h0});
    push_beats(2, '{we: 1'b0, sel: 4'hF, addr: 32'h300, data: 32'h0});
    exp_if.push_back(32'h0000_AAAA);
    if_ce_i = 1; if_addr_i = 32'h200;
    tick();
    tick(); flush_i = 1; if_addr_i = 32'h300;
    tick(); flush_i = 0;
    @(negedge clk);
    chk("flush_no_done_stall", {31'd0, if_stallreq_o}, 32'd1);
    chk("flush_if_data_kept", if_data_o, 32'h1234_5678);
    chk("flush_idle_bus_ce", {31'd0, bus_ce_o}, 32'd0);
    ram_rd = 32'h0000_AAAA;
    wait_low(1'b0, n_if);
    chk("refetch_stall_cycles", n_if, 32'd2);
    tick(); if_ce_i = 0;

    // Reset asserted in the 1st BUSY_D cycle
    tick();
    mem_ce_i = 1; mem_addr_i = 32'h40;
    tick(); reset_n = 0; if_ce_i = 1;
    @(negedge clk);
    chk("rst_mem_stall", {31'd0, mem_stallreq_o}, 32'd0);
    chk("rst_if_stall", {31'd0, if_stallreq_o}, 32'd0);
    tick();
    @(negedge clk);
    chk("rst_mid_bus_ce", {31'd0, bus_ce_o}, 32'd0);
    chk("rst_mid_mem_data", mem_data_o, 32'd0);
    chk("rst_mid_if_data", if_data_o, 32'd0);
    chk("rst_mid_mem_stall", {31'd0, mem_stallreq_o}, 32'd0);
    tick(); reset_n = 1; mem_ce_i = 0; if_ce_i = 0;
    tick();

    // WAIT_CYCLES=1: four back-to-back fetches, 3 cycles each
    if_ce1 = 1; if_addr1 = 32'h400;
    last_done = 0;
    for (int k = 0; k < 4; k++) begin
      n_if = 0; hi = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus_ce1) begin
          hi++;
          chk("w1_bus_addr", bus_addr1, 32'h400 + 32'(4 * k));
        end
        if (!if_stall1) break;
        n_if++;
      end
      chk("w1_stall_cycles", n_if, 32'd2);
      chk("w1_ce_pulses", hi, 32'd1);
      chk("w1_if_data", if_data1, (32'h400 + 32'(4 * k)) ^ 32'hFFFF_0000);
      if (k > 0) chk("w1_period", cyc - last_done, 32'd3);
      last_done = cyc;
      tick(); if_addr1 = 32'h400 + 32'(4 * (k + 1));
    end
    if_ce1 = 0;

    tick(); tick();
    chk("bus_queue_drained", exp_bus.size(), 32'd0);
    chk("if_queue_drained", exp_if.size(), 32'd0);
    chk("mem_queue_drained", exp_mem.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port, fixed-latency RAM bus between the instruction-fetch port and the MEM-stage load/store port.
- The MEM stage's ram_ce/we/sel/addr/data outputs connect to the data side. The PC/fetch logic connects to the instruction side.
- Grants one transaction at a time, data side first.
- Raises per-requester stall requests to the pipeline controller until each requester's transaction completes.

Parameters:
- WAIT_CYCLES, 2: cycles bus_ce_o is held per transaction; read data is sampled on the last cycle. Legal range 1..15.
- CNT_W, 4: width of the wait counter; must hold WAIT_CYCLES-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset_n  in  1  synchronous active-low reset
- if_ce_i  in  1  instruction fetch request; held high until if_stallreq_o falls
- if_addr_i  in  32  fetch address (word aligned)
- if_data_o  out  32  fetched instruction; valid in DONE_I
- if_stallreq_o  out  1  stall request for the fetch side
- mem_ce_i  in  1  data access request; held high until mem_stallreq_o falls
- mem_we_i  in  1  1 = write, 0 = read
- mem_sel_i  in  4  byte lane enables
- mem_addr_i  in  32  data address
- mem_data_i  in  32  store data
- mem_data_o  out  32  load data; valid in DONE_D
- mem_stallreq_o  out  1  stall request for the MEM side
- flush_i  in  1  pipeline flush; discards a pending fetch result
- bus_ce_o  out  1  RAM chip enable
- bus_we_o  out  1  RAM write enable
- bus_sel_o  out  4  RAM byte selects
- bus_addr_o  out  32  RAM address
- bus_data_o  out  32  RAM write data
- bus_data_i  in  32  RAM read data

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low.
- Reset: state=IDLE, counter=0, all registered outputs 0 (bus_*, if_data_o, mem_data_o).
- Stall outputs are combinational:
  - if_stallreq_o = if_ce_i & (state != DONE_I)
  - mem_stallreq_o = mem_ce_i & (state != DONE_D)
  - Both are 0 while reset_n = 0.
- FSM states: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- IDLE:
  - mem_ce_i=1 -> latch mem_we/sel/addr/data into the bus registers, counter=0, go BUSY_D.
  - else if_ce_i=1 -> latch if_addr_i with we=0, sel=4'b1111, data=0, go BUSY_I.
  - else stay in IDLE.
  - Data wins a simultaneous request; fetch waits.
- BUSY_x:
  - bus_ce_o=1; the bus_* fields hold their latched values throughout.
  - Counter increments each cycle.
  - When counter==WAIT_CYCLES-1: sample bus_data_i into if_data_o (BUSY_I) or mem_data_o (BUSY_D, read only), then go to DONE_x.
- DONE_x:
  - bus_ce_o=0 and all bus_* outputs 0.
  - The corresponding stall is low for exactly this one cycle.
  - The captured data output holds until the next capture.
  - Next state IDLE, unconditionally.
- Data-side write: mem_data_o is cleared to 0 on entry to DONE_D.
- Latency: request seen in IDLE at cycle t -> bus_ce_o high in cycles t+1..t+WAIT_CYCLES -> DONE at t+WAIT_CYCLES+1. The requester sees WAIT_CYCLES+1 stall cycles when uncontended.
- Back-to-back: after DONE_x the FSM always passes through IDLE, so sustained throughput is one transaction per WAIT_CYCLES+2 cycles.
- flush_i:
  - In BUSY_I: the bus transaction runs to completion (it is never truncated), but a sticky discard flag is set.
  - At completion with the discard flag set: go IDLE instead of DONE_I, leave if_data_o unchanged, clear the flag.
  - flush_i has no effect on BUSY_D/DONE_D.
  - In IDLE: flush_i does not block a new grant in the same cycle.
- Requester drops ce mid-BUSY: the transaction still completes. The DONE cycle occurs with the stall output already 0.
- Reset mid-transaction: next edge goes to IDLE, bus_ce_o=0, and the partial transaction is abandoned.
- Counter never wraps: it is reset to 0 on every grant.

Decomposition:
- Shared package: state encoding constants, the WAIT_CYCLES default, and the 4'b1111 full-word select constant.
- No sub-module: the FSM, counter, and bus registers form a single module.

Test Plan:
- WAIT_CYCLES=2, if_ce_i=1, if_addr_i=0x100, bus_data_i=0x3C010001 -> bus_ce_o high 2 cycles with addr 0x100, sel 1111; if_data_o=0x3C010001 in DONE_I; if_stallreq_o high 3 cycles then low 1 cycle.
- mem_ce_i=1, mem_we_i=1, mem_sel_i=4'b0011, mem_addr_i=0x202, mem_data_i=0x0000BEEF -> bus_we_o=1, sel 0011, data 0xBEEF for 2 cycles; mem_data_o=0 in DONE_D.
- if_ce_i and mem_ce_i rise together (load 0x80, bus_data_i=0x12345678) -> data is served first, mem_data_o=0x12345678; fetch starts the cycle after DONE_D; if_stallreq_o stays high until DONE_I (7 cycles total).
- flush_i pulsed in the 2nd BUSY_I cycle -> bus_ce_o still high 2 cycles; no DONE_I state; if_data_o keeps its previous value; FSM returns to IDLE.
- reset_n=0 in the 1st BUSY_D cycle -> next edge: bus_ce_o=0, FSM in IDLE, mem_data_o=0, both stall outputs 0 while reset is held.
- WAIT_CYCLES=1 build, four back-to-back fetches -> each takes 3 cycles; bus_ce_o pulses one cycle each, separated by 2 low cycles.
